// File: rtl/imem_access_arb.sv
// imem_access_arb: arbiter/sequencer sharing a byte-wide instruction memory
// between the CPU fetch path (word reads) and the program loader (word
// writes, issued as four little-endian byte writes).
// Optional build macro: IMEM_ADDR_CHECK_EN enables fetch/loader address
// checking with an error pulse; without it every address passes through.
module imem_access_arb #(
   parameter int unsigned DEPTH_BYTES = 1024,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [31:0]       f_rdata,
   input  logic              l_req,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [31:0]       l_wdata,
   output logic              l_gnt,
   output logic              l_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              busy,
   output logic              err
);

   localparam logic [31:0]       LP_NOP       = 32'h0000_0013;
   localparam logic [ADDR_W-1:0] LP_LAST_WORD = ADDR_W'(DEPTH_BYTES - 4);
`ifdef IMEM_ADDR_CHECK_EN
   localparam bit LP_ADDR_CHECK = 1'b1;
`else
   localparam bit LP_ADDR_CHECK = 1'b0;
`endif

   typedef enum logic {S_IDLE = 1'b0, S_WR = 1'b1} state_t;
   typedef enum logic {G_FETCH = 1'b0, G_LOADER = 1'b1} gnt_t;

   state_t            r_state;
   state_t            w_next_state;
   gnt_t              r_last_gnt;
   logic [1:0]        r_cnt;
   logic [ADDR_W-1:0] r_base;
   logic [31:0]       r_wdata;
   logic              r_err;

   logic w_idle;
   logic w_l_sel;
   logic w_f_sel;
   logic w_f_bad;
   logic w_l_bad;

   // Round-robin arbitration, only in IDLE and never while reset is applied
   assign w_idle  = (r_state == S_IDLE) && !rst;
   assign w_l_sel = w_idle && l_req && (!f_req || (r_last_gnt == G_FETCH));
   assign w_f_sel = w_idle && f_req && !w_l_sel;

   // Address checks collapse to constant 0 when the check build is off
   assign w_f_bad = LP_ADDR_CHECK &&
                    ((f_addr[1:0] != 2'b00) || (f_addr > LP_LAST_WORD));
   assign w_l_bad = LP_ADDR_CHECK && (l_addr > LP_LAST_WORD);

   assign err = r_err;

   // State register
   always_ff @(posedge clk) begin : p_state
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Next state: a good loader grant starts the 4-byte write sequence
   always_comb begin : p_next
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_l_sel && !w_l_bad) w_next_state = S_WR;
         S_WR:    if (r_cnt == 2'd3) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Grants and memory port drive; everything idles while reset is high
   always_comb begin : p_out
      f_gnt     = 1'b0;
      l_gnt     = 1'b0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = 8'h00;
      busy      = (r_state == S_WR);
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               f_gnt = w_f_sel;
               l_gnt = w_l_sel;
               if (w_f_sel && !w_f_bad) mem_addr = f_addr;
            end
            S_WR: begin
               mem_we    = 1'b1;
               mem_addr  = r_base + ADDR_W'(r_cnt);
               mem_wdata = r_wdata[{r_cnt, 3'b000} +: 8];
            end
            default: ;
         endcase
      end
   end

   // Fetch response, loader word latch, byte counter and completion pulses
   always_ff @(posedge clk) begin : p_data
      if (rst) begin
         f_rvalid   <= 1'b0;
         f_rdata    <= 32'h0;
         l_done     <= 1'b0;
         r_err      <= 1'b0;
         r_cnt      <= 2'd0;
         r_last_gnt <= G_FETCH;
         r_base     <= '0;
         r_wdata    <= 32'h0;
      end else begin
         f_rvalid <= f_gnt;
         if (f_gnt) f_rdata <= w_f_bad ? LP_NOP : mem_rdata;
         l_done <= ((r_state == S_WR) && (r_cnt == 2'd3)) || (l_gnt && w_l_bad);
         r_err  <= (f_gnt && w_f_bad) || (l_gnt && w_l_bad);
         if (r_state == S_WR) r_cnt <= r_cnt + 2'd1;
         if (l_gnt) begin
            r_base     <= l_addr;
            r_wdata    <= l_wdata;
            r_cnt      <= 2'd0;
            r_last_gnt <= G_LOADER;
         end else if (f_gnt) begin
            r_last_gnt <= G_FETCH;
         end
      end
   end

endmodule

// File: tb/tb_imem_access_arb.sv
// Bench for imem_access_arb: byte memory array model, directed scenarios and
// a randomized run against a transaction-level reference model.
module tb_imem_access_arb;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned AW    = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          f_req, f_gnt, f_rvalid;
   logic [AW-1:0] f_addr;
   logic [31:0]   f_rdata;
   logic          l_req, l_gnt, l_done;
   logic [AW-1:0] l_addr;
   logic [31:0]   l_wdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [7:0]    mem_wdata;
   logic [31:0]   mem_rdata;
   logic          busy, err;

   int errors = 0;
   int checks = 0;

   logic [7:0] mem     [DEPTH];
   logic [7:0] ref_mem [DEPTH];
   logic       bd_we, bd_fill;
   logic [9:0] bd_addr;
   logic [31:0] bd_data;

   imem_access_arb #(.DEPTH_BYTES(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt), .l_done(l_done),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(int i);
      return 8'((i * 37 + 11) % 256);
   endfunction

   // Memory array: combinational little-endian word read, byte write port
   wire [9:0] w_i = mem_addr[9:0];
   assign mem_rdata = {mem[w_i + 10'd3], mem[w_i + 10'd2], mem[w_i + 10'd1], mem[w_i]};

   always @(posedge clk) begin
      if (bd_fill) for (int i = 0; i < int'(DEPTH); i++) mem[i] <= pat(i);
      if (bd_we) for (int b = 0; b < 4; b++) mem[bd_addr + 10'(b)] <= bd_data[8*b +: 8];
      if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_addr = '0; l_wdata = 32'h0;
   endtask

   task automatic fill_mem();
      bd_fill = 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = pat(i);
      tick();
      bd_fill = 1'b0;
   endtask

   task automatic bd_word(input logic [9:0] a, input logic [31:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      tick();
      bd_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; f_req = 1'b1; l_req = 1'b1; f_addr = 32'h8; l_addr = 32'h40;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++; if (f_gnt !== 1'b0) begin errors++; $display("FAIL rst_f_gnt got=%b exp=0", f_gnt); end
         checks++; if (l_gnt !== 1'b0) begin errors++; $display("FAIL rst_l_gnt got=%b exp=0", l_gnt); end
         checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
         tick();
      end
      rst = 1'b0; idle_inputs();
      #1;
      checks++; if (f_rvalid !== 1'b0) begin errors++; $display("FAIL rst_f_rvalid got=%b exp=0", f_rvalid); end
      checks++; if (l_done !== 1'b0) begin errors++; $display("FAIL rst_l_done got=%b exp=0", l_done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL idle_mem_addr got=%h exp=0", mem_addr); end
      tick();
   endtask

   task automatic test_fetch_stream();
      bd_word(10'h000, 32'h0050_0093);
      bd_word(10'h004, 32'h0010_0113);
      f_req = 1'b1; f_addr = 32'h0;
      #1;
      checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL fs_gnt0 got=%b exp=1", f_gnt); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL fs_addr0 got=%h exp=0", mem_addr); end
      tick();
      checks++; if (f_rvalid !== 1'b1) begin errors++; $display("FAIL fs_rvalid0 got=%b exp=1", f_rvalid); end
      checks++; if (f_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fs_rdata0 got=%h exp=00500093", f_rdata); end
      f_addr = 32'h4;
      #1;
      checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL fs_gnt1 got=%b exp=1", f_gnt); end
      tick();
      checks++; if (f_rvalid !== 1'b1) begin errors++; $display("FAIL fs_rvalid1 got=%b exp=1", f_rvalid); end
      checks++; if (f_rdata !== 32'h0010_0113) begin errors++; $display("FAIL fs_rdata1 got=%h exp=00100113", f_rdata); end
      f_req = 1'b0;
      tick();
      checks++; if (f_rvalid !== 1'b0) begin errors++; $display("FAIL fs_rvalid_end got=%b exp=0", f_rvalid); end
   endtask

   task automatic test_loader_write();
      logic [31:0] d;
      d = 32'hDEAD_BEEF;
      l_req = 1'b1; l_addr = 32'h10; l_wdata = d;
      #1;
      checks++; if (l_gnt !== 1'b1) begin errors++; $display("FAIL lw_gnt got=%b exp=1", l_gnt); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL lw_gnt_we got=%b exp=0", mem_we); end
      tick();
      l_req = 1'b0; f_req = 1'b1; f_addr = 32'h10;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL lw_we%0d got=%b exp=1", k, mem_we); end
         checks++; if (mem_addr !== 32'h10 + 32'(k)) begin errors++; $display("FAIL lw_addr%0d got=%h exp=%h", k, mem_addr, 32'h10 + 32'(k)); end
         checks++; if (mem_wdata !== d[8*k +: 8]) begin errors++; $display("FAIL lw_byte%0d got=%h exp=%h", k, mem_wdata, d[8*k +: 8]); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lw_busy%0d got=%b exp=1", k, busy); end
         checks++; if (f_gnt !== 1'b0) begin errors++; $display("FAIL lw_fgnt%0d got=%b exp=0", k, f_gnt); end
         tick();
      end
      #1;
      checks++; if (l_done !== 1'b1) begin errors++; $display("FAIL lw_done got=%b exp=1", l_done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lw_busy_end got=%b exp=0", busy); end
      checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL lw_fgnt_exit got=%b exp=1", f_gnt); end
      tick();
      checks++; if (f_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_readback got=%h exp=deadbeef", f_rdata); end
      checks++; if (l_done !== 1'b0) begin errors++; $display("FAIL lw_done_pulse got=%b exp=0", l_done); end
      f_req = 1'b0;
      tick();
   endtask

   task automatic test_conflict();
      rst = 1'b1; tick(); rst = 1'b0;
      f_req = 1'b1; f_addr = 32'h0; l_req = 1'b1; l_addr = 32'h20; l_wdata = 32'h1122_3344;
      #1;
      checks++; if (l_gnt !== 1'b1 || f_gnt !== 1'b0) begin errors++; $display("FAIL cf_first got=l%b/f%b exp=l1/f0", l_gnt, f_gnt); end
      tick();
      l_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (f_gnt !== 1'b0) begin errors++; $display("FAIL cf_wr_fgnt%0d got=%b exp=0", k, f_gnt); end
         tick();
      end
      l_req = 1'b1; l_addr = 32'h24; l_wdata = 32'h5566_7788;
      #1;
      checks++; if (f_gnt !== 1'b1 || l_gnt !== 1'b0) begin errors++; $display("FAIL cf_second got=f%b/l%b exp=f1/l0", f_gnt, l_gnt); end
      tick();
      checks++; if (f_rdata !== 32'h0050_0093) begin errors++; $display("FAIL cf_fdata got=%h exp=00500093", f_rdata); end
      f_addr = 32'h4;
      #1;
      checks++; if (l_gnt !== 1'b1 || f_gnt !== 1'b0) begin errors++; $display("FAIL cf_third got=l%b/f%b exp=l1/f0", l_gnt, f_gnt); end
      tick();
      idle_inputs();
      repeat (4) tick();
      checks++; if (l_done !== 1'b1) begin errors++; $display("FAIL cf_done got=%b exp=1", l_done); end
      f_req = 1'b1; f_addr = 32'h20;
      tick();
      checks++; if (f_rdata !== 32'h1122_3344) begin errors++; $display("FAIL cf_readback got=%h exp=11223344", f_rdata); end
      f_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_write();
      l_req = 1'b1; l_addr = 32'h10; l_wdata = 32'hCAFE_F00D;
      #1;
      checks++; if (l_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt got=%b exp=1", l_gnt); end
      tick();
      l_req = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rm_we_in_rst got=%b exp=0", mem_we); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rm_we_after got=%b exp=0", mem_we); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", busy); end
      checks++; if (l_done !== 1'b0) begin errors++; $display("FAIL rm_done0 got=%b exp=0", l_done); end
      tick();
      checks++; if (l_done !== 1'b0) begin errors++; $display("FAIL rm_done1 got=%b exp=0", l_done); end
      checks++; if ({mem[19], mem[18], mem[17], mem[16]} !== 32'hDEAD_F00D) begin
         errors++; $display("FAIL rm_bytes got=%h exp=deadf00d", {mem[19], mem[18], mem[17], mem[16]}); end
      f_req = 1'b1; f_addr = 32'h10;
      #1;
      checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL rm_idle_fgnt got=%b exp=1", f_gnt); end
      tick();
      checks++; if (f_rdata !== 32'hDEAD_F00D) begin errors++; $display("FAIL rm_readback got=%h exp=deadf00d", f_rdata); end
      f_req = 1'b0;
      tick();
   endtask

`ifdef IMEM_ADDR_CHECK_EN
   task automatic test_addr_check();
      rst = 1'b1; tick(); rst = 1'b0;
      bd_word(10'h3FC, 32'hA1B2_C3D4);
      f_req = 1'b1; f_addr = 32'h3FE;
      #1;
      checks++; if (f_gnt !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL ac_bad_gnt got=%b/%h exp=1/0", f_gnt, mem_addr); end
      tick();
      checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'h13) begin errors++; $display("FAIL ac_nop got=%b/%h exp=1/00000013", f_rvalid, f_rdata); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ac_ferr got=%b exp=1", err); end
      f_addr = 32'h3FC;
      tick();
      checks++; if (f_rdata !== 32'hA1B2_C3D4 || err !== 1'b0) begin errors++; $display("FAIL ac_good got=%h/%b exp=a1b2c3d4/0", f_rdata, err); end
      f_req = 1'b0; l_req = 1'b1; l_addr = 32'h400; l_wdata = 32'h1234_5678;
      #1;
      checks++; if (l_gnt !== 1'b1) begin errors++; $display("FAIL ac_lgnt got=%b exp=1", l_gnt); end
      tick();
      l_req = 1'b0;
      checks++; if (mem_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ac_lskip got=%b/%b exp=0/0", mem_we, busy); end
      checks++; if (l_done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL ac_lerr got=%b/%b exp=1/1", l_done, err); end
      tick();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL ac_err_pulse got=%b exp=0", err); end
   endtask
`endif

   // Transaction-level model: a loader grant owns the memory for the next
   // 4 cycles; otherwise round-robin between held requests.
   task automatic test_random();
      int cyc, wr_start, k;
      bit fp, lp, last_loader, in_wr, eg_f, eg_l, exp_rvalid, exp_done;
      logic [31:0] fa, la, ld, wr_base, wr_data, exp_rdata;
      logic [9:0] ai;
      rst = 1'b1; idle_inputs(); tick(); rst = 1'b0;
      fill_mem();
      cyc = 0; wr_start = -100; fp = 0; lp = 0; last_loader = 0;
      exp_rvalid = 0; exp_done = 0; exp_rdata = 0; fa = 0; la = 0; ld = 0; wr_base = 0; wr_data = 0;
      for (int n = 0; n < 400; n++) begin
         in_wr = (cyc >= wr_start) && (cyc < wr_start + 4);
         checks++; if (f_rvalid !== exp_rvalid) begin errors++; $display("FAIL rnd_rvalid c%0d got=%b exp=%b", cyc, f_rvalid, exp_rvalid); end
         if (exp_rvalid) begin
            checks++; if (f_rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata c%0d got=%h exp=%h", cyc, f_rdata, exp_rdata); end
         end
         checks++; if (l_done !== exp_done) begin errors++; $display("FAIL rnd_done c%0d got=%b exp=%b", cyc, l_done, exp_done); end
         checks++; if (busy !== in_wr) begin errors++; $display("FAIL rnd_busy c%0d got=%b exp=%b", cyc, busy, in_wr); end
         if (!fp && $urandom_range(0, 2) == 0) begin fp = 1; fa = 32'($urandom_range(0, 15) * 4); end
         if (!lp && $urandom_range(0, 5) == 0) begin lp = 1; la = 32'($urandom_range(0, 15) * 4); ld = $urandom; end
         f_req = fp; f_addr = fa; l_req = lp; l_addr = la; l_wdata = ld;
         eg_f = 0; eg_l = 0;
         if (!in_wr) begin
            if (lp && (!fp || !last_loader)) eg_l = 1;
            else if (fp) eg_f = 1;
         end
         #1;
         checks++; if (f_gnt !== eg_f || l_gnt !== eg_l) begin errors++; $display("FAIL rnd_gnt c%0d got=f%b/l%b exp=f%b/l%b", cyc, f_gnt, l_gnt, eg_f, eg_l); end
         checks++; if (mem_we !== in_wr) begin errors++; $display("FAIL rnd_we c%0d got=%b exp=%b", cyc, mem_we, in_wr); end
         if (in_wr) begin
            k = cyc - wr_start;
            checks++; if (mem_addr !== wr_base + 32'(k) || mem_wdata !== 8'(wr_data >> (8 * k))) begin
               errors++; $display("FAIL rnd_wbyte c%0d got=%h/%h exp=%h/%h", cyc, mem_addr, mem_wdata, wr_base + 32'(k), 8'(wr_data >> (8 * k))); end
         end else begin
            checks++; if (mem_addr !== (eg_f ? fa : 32'h0) || mem_wdata !== 8'h0) begin
               errors++; $display("FAIL rnd_idle_addr c%0d got=%h/%h exp=%h/00", cyc, mem_addr, mem_wdata, eg_f ? fa : 32'h0); end
         end
         exp_rvalid = eg_f;
         if (eg_f) begin
            ai = fa[9:0];
            exp_rdata = {ref_mem[ai + 10'd3], ref_mem[ai + 10'd2], ref_mem[ai + 10'd1], ref_mem[ai]};
            fp = 0; last_loader = 0;
         end
         exp_done = in_wr && (cyc - wr_start == 3);
         if (exp_done) for (int b = 0; b < 4; b++) ref_mem[wr_base[9:0] + 10'(b)] = wr_data[8*b +: 8];
         if (eg_l) begin
            wr_start = cyc + 1; wr_base = la; wr_data = ld; lp = 0; last_loader = 1;
         end
         cyc++;
         tick();
      end
      idle_inputs();
      repeat (5) tick();
   endtask

   initial begin
      rst = 1'b1; bd_we = 1'b0; bd_fill = 1'b0; bd_addr = '0; bd_data = 32'h0;
      idle_inputs();
      fill_mem();
      test_reset();
      test_fetch_stream();
      test_loader_write();
      test_conflict();
      test_reset_mid_write();
`ifdef IMEM_ADDR_CHECK_EN
      test_addr_check();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
